// File: rtl/satatrn_txarb_pkg.sv
// -----------------------------------------------------------------------------
// satatrn_txarb_pkg
// Shared transport-layer definitions: FIS type codes, transmit arbiter state
// encoding and the drain-source tag.
// -----------------------------------------------------------------------------
package satatrn_txarb_pkg;

    localparam logic [7:0] FIS_REG_H2D = 8'h27;
    localparam logic [7:0] FIS_DMA_ACT = 8'h39;
    localparam logic [7:0] FIS_DATA    = 8'h46;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REG   = 3'd1,
        ST_DHDR  = 3'd2,
        ST_DATA  = 3'd3,
        ST_DRAIN = 3'd4
    } state_e;

    // Which input source was mid-packet when a link error hit.
    typedef enum logic {
        SRC_REG  = 1'b0,
        SRC_DATA = 1'b1
    } src_e;

    // First dword of every data FIS: type byte in [31:24], remaining bytes zero.
    function automatic logic [31:0] data_fis_header();
        return {FIS_DATA, 24'h0};
    endfunction

endpackage

// File: rtl/satatrn_txarb_if.sv
// -----------------------------------------------------------------------------
// satatrn_txarb_if
// Handshake bundle of the transport transmit arbiter.
//   reg  stream : i_reg_valid / o_reg_ready / i_reg_data[31:0] / i_reg_last
//   data stream : i_data_valid / o_data_ready / i_data_data[31:0] / i_data_last
//   link stream : o_valid / i_ready / o_data[31:0] / o_last
// Signal prefixes are from the arbiter's point of view. The arbiter uses the
// slave modport; the command/DMA engines plus link layer side uses master.
// -----------------------------------------------------------------------------
interface satatrn_txarb_if;

    logic        i_reg_valid;
    logic        o_reg_ready;
    logic [31:0] i_reg_data;
    logic        i_reg_last;

    logic        i_data_valid;
    logic        o_data_ready;
    logic [31:0] i_data_data;
    logic        i_data_last;

    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_data;
    logic        o_last;

    modport slave (
        input  i_reg_valid, i_reg_data, i_reg_last,
        output o_reg_ready,
        input  i_data_valid, i_data_data, i_data_last,
        output o_data_ready,
        output o_valid, o_data, o_last,
        input  i_ready
    );

    modport master (
        output i_reg_valid, i_reg_data, i_reg_last,
        input  o_reg_ready,
        output i_data_valid, i_data_data, i_data_last,
        input  o_data_ready,
        input  o_valid, o_data, o_last,
        output i_ready
    );

endinterface

// File: rtl/satatrn_txarb.sv
// -----------------------------------------------------------------------------
// satatrn_txarb
// Transport-layer transmit arbiter. Merges register FISs and outgoing data
// payload into one dword stream toward the link layer, inserting the data FIS
// header and splitting payload into FISs of at most 2^LGMAXDW dwords. Each data
// FIS needs its own DMA-activate grant; a link error aborts the current FIS and
// discards the remainder of the in-flight input packet.
//
// Ports:
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   i_link_err       : link-layer error, aborts the current FIS
//   i_dma_go         : one-cycle DMA-activate pulse, permits one data FIS
//   bus (slave)      : reg / data input streams, link output stream
//   o_busy           : state not idle or an output dword is pending
// -----------------------------------------------------------------------------
module satatrn_txarb
    import satatrn_txarb_pkg::*;
#(
    parameter int LGMAXDW = 11
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_link_err,
    input  logic             i_dma_go,
    satatrn_txarb_if.slave   bus,
    output logic             o_busy
);

    localparam logic [LGMAXDW:0] CNT_ONE    = {{LGMAXDW{1'b0}}, 1'b1};
    localparam logic [LGMAXDW:0] CHUNK_LAST = {1'b0, {LGMAXDW{1'b1}}};

    state_e           state_q, state_d;
    logic             pending_q, pending_d;
    logic [LGMAXDW:0] count_q, count_d;
    src_e             drain_src_q, drain_src_d;
    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_data_q, out_data_d;
    logic             out_last_q, out_last_d;

    logic load_en;
    logic reg_ready, data_ready;
    logic reg_acc, data_acc;
    logic data_fis_end;
    logic drain_done;

    // Output register can take a new dword when empty or being drained this cycle.
    assign load_en    = !out_valid_q || bus.i_ready;
    assign reg_ready  = (state_q == ST_DRAIN) || (load_en && (state_q == ST_REG));
    assign data_ready = (state_q == ST_DRAIN) || (load_en && (state_q == ST_DATA));
    assign reg_acc    = bus.i_reg_valid  && reg_ready;
    assign data_acc   = bus.i_data_valid && data_ready;

    // A data FIS ends on the transfer's last dword or when the chunk is full.
    assign data_fis_end = bus.i_data_last || (count_q == CHUNK_LAST);

    assign drain_done = (drain_src_q == SRC_REG) ? (bus.i_reg_valid  && bus.i_reg_last)
                                                 : (bus.i_data_valid && bus.i_data_last);

    // NOTE: every next-state variable gets its hold value first, so no path
    // through the case statements can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q || i_dma_go;
        count_d     = count_q;
        drain_src_d = drain_src_q;
        out_valid_d = load_en ? 1'b0 : out_valid_q;
        out_last_d  = load_en ? 1'b0 : out_last_q;
        out_data_d  = out_data_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.i_reg_valid) begin
                    state_d = ST_REG;
                end else if (pending_q && bus.i_data_valid) begin
                    state_d = ST_DHDR;
                end
            end
            ST_REG: begin
                if (reg_acc) begin
                    out_valid_d = 1'b1;
                    out_data_d  = bus.i_reg_data;
                    out_last_d  = bus.i_reg_last;
                    if (bus.i_reg_last) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DHDR: begin
                if (load_en) begin
                    out_valid_d = 1'b1;
                    out_data_d  = data_fis_header();
                    out_last_d  = 1'b0;
                    // The grant is consumed, but a go arriving right now is kept.
                    pending_d   = i_dma_go;
                    count_d     = '0;
                    state_d     = ST_DATA;
                end
            end
            ST_DATA: begin
                if (data_acc) begin
                    out_valid_d = 1'b1;
                    out_data_d  = bus.i_data_data;
                    out_last_d  = data_fis_end;
                    count_d     = count_q + CNT_ONE;
                    if (data_fis_end) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Link error overrides everything: drop the output dword and any grant.
        if (i_link_err) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            pending_d   = 1'b0;
            case (state_q)
                ST_REG: begin
                    if (reg_acc && bus.i_reg_last) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d     = ST_DRAIN;
                        drain_src_d = SRC_REG;
                    end
                end
                ST_DATA: begin
                    if (data_acc && bus.i_data_last) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d     = ST_DRAIN;
                        drain_src_d = SRC_DATA;
                    end
                end
                ST_DRAIN: begin
                    // Keep discarding; state_d already reflects drain completion.
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= ST_IDLE;
            pending_q   <= 1'b0;
            count_q     <= '0;
            drain_src_q <= SRC_REG;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            count_q     <= count_d;
            drain_src_q <= drain_src_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign bus.o_reg_ready  = reg_ready;
    assign bus.o_data_ready = data_ready;
    assign bus.o_valid      = out_valid_q;
    assign bus.o_data       = out_data_q;
    assign bus.o_last       = out_last_q;
    assign o_busy           = (state_q != ST_IDLE) || out_valid_q;

endmodule

// File: tb/tb_satatrn_txarb.sv
// -----------------------------------------------------------------------------
// tb_satatrn_txarb
// Self-checking bench for satatrn_txarb (LGMAXDW = 2, so 4-dword data FISs).
// A per-source scoreboard predicts the link stream: register FISs pass intact,
// data transfers are cut into chunks of min(4, remaining) dwords, each chunk
// preceded by 32'h4600_0000 and backed by a DMA-activate grant.
// -----------------------------------------------------------------------------
module tb_satatrn_txarb;

    localparam int          LGMAXDW = 2;
    localparam int          MAXDW   = 1 << LGMAXDW;
    localparam logic [31:0] HDR     = 32'h4600_0000;

    typedef struct {
        logic [31:0] d;
        logic        l;
    } word_t;

    logic i_clk = 1'b0;
    logic i_reset_n = 1'b0;
    logic i_link_err = 1'b0;
    logic i_dma_go = 1'b0;
    logic o_busy;

    satatrn_txarb_if bus();

    satatrn_txarb #(.LGMAXDW(LGMAXDW)) dut (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_link_err (i_link_err),
        .i_dma_go   (i_dma_go),
        .bus        (bus),
        .o_busy     (o_busy)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    word_t reg_src[$], data_src[$];     // words still to be offered by the sources
    word_t exp_reg[$], exp_data[$];     // words still expected on the link
    word_t out_log[$];                  // every dword the link accepted
    int    out_cyc[$], reg_acc_cyc[$];
    int    data_acc_n = 0;

    bit mon_en = 1'b0;
    bit gap_mode = 1'b0;
    int ready_mode = 0;                 // 0 always ready, 1 toggle, 2 random
    int grants_out = 0;
    int fis_kind = 0;                   // 0 between FISs, 1 register FIS, 2 data FIS
    int chunk_left = 0;
    bit reg_hs = 1'b0, data_hs = 1'b0;
    bit prev_stall = 1'b0;
    logic [31:0] prev_d = '0;
    logic prev_l = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int data_rem();
        int n = 0;
        for (int i = 0; i < exp_data.size(); i++) begin
            n++;
            if (exp_data[i].l) return n;
        end
        return n;
    endfunction

    task automatic score(input logic [31:0] d, input logic l);
        word_t e;
        int r;
        if (fis_kind == 0 && d == HDR) begin
            check("hdr_grant", 32'(grants_out > 0), 1);
            if (grants_out > 0) grants_out--;
            check("hdr_last", l, 1'b0);
            r = data_rem();
            chunk_left = (r < MAXDW) ? r : MAXDW;
            fis_kind = 2;
        end else if (fis_kind != 2) begin
            fis_kind = 1;
            if (exp_reg.size() == 0) begin
                check("reg_extra", exp_reg.size(), 1);
            end else begin
                e = exp_reg.pop_front();
                check("reg_data", d, e.d);
                check("reg_last", l, e.l);
                if (e.l) fis_kind = 0;
            end
        end else begin
            if (exp_data.size() == 0) begin
                check("data_extra", exp_data.size(), 1);
            end else begin
                e = exp_data.pop_front();
                check("data_data", d, e.d);
                check("data_last", l, 32'(chunk_left == 1));
            end
            chunk_left--;
            if (chunk_left <= 0) fis_kind = 0;
        end
    endtask

    always @(posedge i_clk) cyc <= cyc + 1;

    // Sample handshakes and the link stream mid-cycle, away from the edge.
    always @(negedge i_clk) begin
        reg_hs  = bus.i_reg_valid && bus.o_reg_ready;
        data_hs = bus.i_data_valid && bus.o_data_ready;
        if (i_reset_n) begin
            if (reg_hs) reg_acc_cyc.push_back(cyc);
            if (data_hs) data_acc_n++;
            if (bus.o_valid && !prev_stall) out_cyc.push_back(cyc);
            if (mon_en && prev_stall) begin
                check("stall_valid", bus.o_valid, 1'b1);
                check("stall_data", bus.o_data, prev_d);
                check("stall_last", bus.o_last, prev_l);
            end
            if (bus.o_valid && bus.i_ready) begin
                word_t w;
                w.d = bus.o_data;
                w.l = bus.o_last;
                out_log.push_back(w);
                if (mon_en) score(bus.o_data, bus.o_last);
            end
            prev_stall = bus.o_valid && !bus.i_ready;
            prev_d = bus.o_data;
            prev_l = bus.o_last;
        end
    end

    // Source and sink driver: updates two time units after each rising edge.
    initial begin : drive
        word_t w;
        bus.i_reg_valid = 1'b0;  bus.i_reg_data = '0;  bus.i_reg_last = 1'b0;
        bus.i_data_valid = 1'b0; bus.i_data_data = '0; bus.i_data_last = 1'b0;
        bus.i_ready = 1'b1;
        forever begin
            @(posedge i_clk);
            #2;
            if (reg_hs && reg_src.size() > 0) w = reg_src.pop_front();
            if (data_hs && data_src.size() > 0) w = data_src.pop_front();
            if (reg_src.size() > 0 && (!gap_mode || $urandom_range(0, 3) != 0)) begin
                bus.i_reg_valid = 1'b1;
                bus.i_reg_data = reg_src[0].d;
                bus.i_reg_last = reg_src[0].l;
            end else begin
                bus.i_reg_valid = 1'b0;
            end
            if (data_src.size() > 0 && (!gap_mode || $urandom_range(0, 3) != 0)) begin
                bus.i_data_valid = 1'b1;
                bus.i_data_data = data_src[0].d;
                bus.i_data_last = data_src[0].l;
            end else begin
                bus.i_data_valid = 1'b0;
            end
            case (ready_mode)
                0:       bus.i_ready = 1'b1;
                1:       bus.i_ready = ~bus.i_ready;
                default: bus.i_ready = ($urandom_range(0, 9) < 7);
            endcase
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic pulse_go();
        i_dma_go = 1'b1;
        grants_out++;
        tick(1);
        i_dma_go = 1'b0;
    endtask

    task automatic add_word(input bit is_reg, input logic [31:0] d, input logic l, input bit track);
        word_t w;
        w.d = d;
        w.l = l;
        if (is_reg) begin
            reg_src.push_back(w);
            if (track) exp_reg.push_back(w);
        end else begin
            data_src.push_back(w);
            if (track) exp_data.push_back(w);
        end
    endtask

    task automatic add_reg(input int n, input logic [31:0] first);
        for (int i = 0; i < n; i++)
            add_word(1'b1, (i == 0) ? first : $urandom, i == n - 1, 1'b1);
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (!(reg_src.size() == 0 && data_src.size() == 0 && exp_reg.size() == 0 &&
                 exp_data.size() == 0 && !o_busy) && n < budget) begin
            tick(1);
            n++;
        end
        check({name, "_done"}, 32'(n < budget), 1);
    endtask

    task automatic clear_logs();
        out_log.delete();
        out_cyc.delete();
        reg_acc_cyc.delete();
        data_acc_n = 0;
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        // Reset values
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check("rst_o_valid", bus.o_valid, 1'b0);
        check("rst_o_last", bus.o_last, 1'b0);
        check("rst_o_data", bus.o_data, 32'h0);
        check("rst_reg_ready", bus.o_reg_ready, 1'b0);
        check("rst_data_ready", bus.o_data_ready, 1'b0);
        check("rst_busy", o_busy, 1'b0);
        @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;
        tick(2);
        mon_en = 1'b1;

        // Register FIS alone, one-cycle latency, no header
        clear_logs();
        add_reg(5, 32'h2780_EC00);
        wait_done("reg5", 100);
        check("reg5_count", out_log.size(), 5);
        if (out_log.size() == 5) begin
            check("reg5_first", out_log[0].d, 32'h2780_EC00);
            check("reg5_last4", out_log[3].l, 1'b0);
            check("reg5_last5", out_log[4].l, 1'b1);
        end
        if (out_cyc.size() > 0 && reg_acc_cyc.size() > 0)
            check("reg5_latency", out_cyc[0] - reg_acc_cyc[0], 1);

        // Data waits for a grant, then header + 3 payload dwords
        clear_logs();
        add_word(1'b0, 32'h1111_1111, 1'b0, 1'b1);
        add_word(1'b0, 32'h2222_2222, 1'b0, 1'b1);
        add_word(1'b0, 32'h3333_3333, 1'b1, 1'b1);
        tick(20);
        check("nogo_silent", out_log.size(), 0);
        check("nogo_held", data_src.size(), 3);
        pulse_go();
        wait_done("data3", 100);
        check("data3_count", out_log.size(), 4);
        if (out_log.size() == 4) begin
            check("data3_hdr", out_log[0].d, HDR);
            check("data3_d1", out_log[1].d, 32'h1111_1111);
            check("data3_d3", out_log[3].d, 32'h3333_3333);
            check("data3_last", out_log[3].l, 1'b1);
        end

        // 6-dword transfer splits into 4 + 2, second chunk waits for its grant
        clear_logs();
        for (int i = 0; i < 6; i++) add_word(1'b0, 32'hC000_0000 + 32'(i), i == 5, 1'b1);
        pulse_go();
        for (int i = 0; i < 60 && out_log.size() < 5; i++) tick(1);
        tick(10);
        check("split_pause", out_log.size(), 5);
        if (out_log.size() == 5) check("split_last1", out_log[4].l, 1'b1);
        pulse_go();
        wait_done("split", 100);
        check("split_count", out_log.size(), 8);
        if (out_log.size() == 8) begin
            check("split_hdr2", out_log[5].d, HDR);
            check("split_end_d", out_log[7].d, 32'hC000_0005);
            check("split_end_l", out_log[7].l, 1'b1);
        end

        // Both sources ready in IDLE with a grant pending: register FIS first
        clear_logs();
        pulse_go();
        add_reg(5, 32'h2780_0001);
        for (int i = 0; i < 3; i++) add_word(1'b0, 32'hD000_0000 + 32'(i), i == 2, 1'b1);
        wait_done("prio", 150);
        check("prio_count", out_log.size(), 9);
        if (out_log.size() == 9) begin
            check("prio_first", out_log[0].d, 32'h2780_0001);
            check("prio_hdr", out_log[5].d, HDR);
        end

        // Link-side back-pressure toggling every cycle during data
        clear_logs();
        ready_mode = 1;
        pulse_go();
        for (int i = 0; i < 4; i++) add_word(1'b0, 32'hE000_0010 + 32'(i), i == 3, 1'b1);
        wait_done("toggle", 150);
        check("toggle_count", out_log.size(), 5);
        if (out_log.size() == 5) check("toggle_d4", out_log[4].d, 32'hE000_0013);
        ready_mode = 0;
        tick(2);

        // Link error after 2 of 5 data dwords: rest is drained silently
        mon_en = 1'b0;
        clear_logs();
        pulse_go();
        for (int i = 0; i < 5; i++) add_word(1'b0, 32'hA000_0001 + 32'(i), i == 4, 1'b0);
        for (int i = 0; i < 100 && data_acc_n < 2; i++) begin
            @(negedge i_clk);
            #1;
        end
        check("err_arm", data_acc_n, 2);
        @(posedge i_clk);
        #1;
        i_link_err = 1'b1;
        @(posedge i_clk);
        #1;
        i_link_err = 1'b0;
        @(negedge i_clk);
        check("err_valid_low", bus.o_valid, 1'b0);
        wait_done("err", 100);
        check("err_count", out_log.size(), 3);
        if (out_log.size() == 3) check("err_d2", out_log[2].d, 32'hA000_0002);
        check("err_drained", data_src.size(), 0);
        check("err_busy", o_busy, 1'b0);
        grants_out = 0;
        fis_kind = 0;
        mon_en = 1'b1;

        // Randomized mix of register FISs and data transfers
        gap_mode = 1'b1;
        ready_mode = 2;
        for (int it = 0; it < 40; it++) begin
            int n;
            int budget;
            if ($urandom_range(0, 1) == 1)
                add_reg($urandom_range(1, 6), {8'h27, 24'($urandom)});
            if ($urandom_range(0, 2) != 0) begin
                n = $urandom_range(1, 10);
                for (int i = 0; i < n; i++) add_word(1'b0, $urandom, i == n - 1, 1'b1);
            end
            budget = 0;
            while (!(reg_src.size() == 0 && data_src.size() == 0 && exp_reg.size() == 0 &&
                     exp_data.size() == 0 && !o_busy) && budget < 1000) begin
                if (grants_out == 0 && data_src.size() > 0 && $urandom_range(0, 3) == 0)
                    pulse_go();
                else
                    tick(1);
                budget++;
            end
            check("rand_done", 32'(budget < 1000), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
